// File: rtl/shift_ctrl.sv
// Button-driven sequencer: synchronises/debounces three buttons and steers a shared right-rotator.
// Optional auto-repeat of held shift buttons is built when SHIFT_CTRL_AUTO_REPEAT_EN is defined.
module shift_ctrl #(
  parameter int WIDTH           = 8,
  parameter int AMT_BITS        = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                mclk,
  input  logic                reset,
  input  logic [2:0]          btn,
  input  logic [WIDTH-1:0]    sw,
  output logic [WIDTH-1:0]    rot_num,
  output logic [AMT_BITS-1:0] rot_amt,
  input  logic [WIDTH-1:0]    rot_result,
  output logic [WIDTH-1:0]    shift_reg,
  output logic [7:0]          op_count,
  output logic                busy,
  output logic                step
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_REL} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_LOAD, CMD_LEFT, CMD_RIGHT} cmd_t;

  logic [2:0]      sync1, sync2, deb, press;
  logic [DB_W-1:0] db_cnt [3];
  state_t          state_q, state_d;
  cmd_t            cmd_q, cmd_d, arb_cmd;
  logic            repeat_fire;

  // press is registered on the same edge deb rises, so it lines up with the new level
  always_ff @(posedge mclk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= sync2[i];
          press[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    arb_cmd = CMD_NONE;
    if (press[2])      arb_cmd = CMD_LOAD;
    else if (press[1]) arb_cmd = CMD_LEFT;
    else if (press[0]) arb_cmd = CMD_RIGHT;
  end

`ifdef SHIFT_CTRL_AUTO_REPEAT_EN
  localparam int RP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  logic [RP_W-1:0] rep_cnt;
  logic            rep_held;

  assign rep_held    = ((cmd_q == CMD_LEFT) && deb[1]) || ((cmd_q == CMD_RIGHT) && deb[0]);
  assign repeat_fire = (state_q == WAIT_REL) && rep_held && (rep_cnt == RP_W'(REPEAT_CYCLES - 1));

  // Counter sits at zero outside WAIT_REL, so each WAIT_REL entry starts a fresh hold interval
  always_ff @(posedge mclk) begin
    if (reset || (state_q != WAIT_REL) || !rep_held || repeat_fire) rep_cnt <= '0;
    else                                                             rep_cnt <= rep_cnt + RP_W'(1);
  end
`else
  assign repeat_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|press) begin
          cmd_d   = arb_cmd;
          state_d = EXEC;
        end
      end
      EXEC: begin
        step    = 1'b1;
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (deb == 3'b000) begin
          cmd_d   = CMD_NONE;
          state_d = IDLE;
        end else if (repeat_fire) begin
          state_d = EXEC;
        end
      end
      default: begin
        cmd_d   = CMD_NONE;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd_q     <= CMD_NONE;
      shift_reg <= '0;
      op_count  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      if (step) begin
        shift_reg <= (cmd_q == CMD_LOAD) ? sw : rot_result;
        op_count  <= op_count + 8'd1;
      end
    end
  end

  // Left-by-2 reuses the right rotator as a rotate by WIDTH-2
  always_comb begin
    rot_amt = '0;
    case (cmd_q)
      CMD_RIGHT: rot_amt = AMT_BITS'(1);
      CMD_LEFT:  rot_amt = AMT_BITS'(WIDTH - 2);
      default:   rot_amt = '0;
    endcase
  end

  assign rot_num = shift_reg;
  assign busy    = (state_q != IDLE);

endmodule
